// File: rtl/reg_file_if.sv
// Register file bus: write port (IN/INADDRESS/WRITE), two read address ports,
// registered read data (OUT1/OUT2) and per-entry written flags (WRITTEN).
// master: drives addresses/write data (datapath side); slave: the register file.
interface reg_file_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] IN;
    logic [ADDR_WIDTH-1:0] INADDRESS;
    logic                  WRITE;
    logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
    logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
    logic [DATA_WIDTH-1:0] OUT1;
    logic [DATA_WIDTH-1:0] OUT2;
    logic [DEPTH-1:0]      WRITTEN;

    modport master (
        output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        input  OUT1, OUT2, WRITTEN
    );

    modport slave (
        input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        output OUT1, OUT2, WRITTEN
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: 2^ADDR_WIDTH x DATA_WIDTH register file, one write port, two
// registered read ports with write-through bypass, per-entry written flags.
// Ports: CLK (rising edge), RESET (async, active high), bus (reg_file_if.slave).
module reg_file #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    reg_file_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DATA_WIDTH-1:0] out1_q, out1_d;
    logic [DATA_WIDTH-1:0] out2_q, out2_d;
    logic [DEPTH-1:0]      written_q, written_d;

    // Next state: apply the write, then read from the post-write view so a
    // same-cycle write to a read address is forwarded to the output.
    always_comb begin
        regs_d    = regs_q;
        written_d = written_q;
        if (bus.WRITE) begin
            regs_d[bus.INADDRESS]    = bus.IN;
            written_d[bus.INADDRESS] = 1'b1;
        end
        out1_d = regs_d[bus.OUT1ADDRESS];
        out2_d = regs_d[bus.OUT2ADDRESS];
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            regs_q    <= '{default: '0};
            out1_q    <= '0;
            out2_q    <= '0;
            written_q <= '0;
        end else begin
            regs_q    <= regs_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
            written_q <= written_d;
        end
    end

    assign bus.OUT1    = out1_q;
    assign bus.OUT2    = out2_q;
    assign bus.WRITTEN = written_q;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed test plan followed by random
// traffic, all compared against an array-based reference model.
module tb_reg_file;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned NR = 8;

    logic CLK;
    logic RESET;

    reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: plain storage array, written flags, expected outputs.
    logic [DW-1:0] mem [NR];
    logic [NR-1:0] wr_model;
    logic [DW-1:0] exp1, exp2;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(NR); i++) mem[i] = '0;
        wr_model = '0;
        exp1 = '0;
        exp2 = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_out1"}, bus.OUT1, exp1);
        check({tag, "_out2"}, bus.OUT2, exp2);
        check({tag, "_written"}, bus.WRITTEN, wr_model);
    endtask

    // One clock cycle of stimulus; inputs change 1 time unit after the edge.
    task automatic cycle(input string tag, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] din, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bus.WRITE       = we;
        bus.INADDRESS   = wa;
        bus.IN          = din;
        bus.OUT1ADDRESS = r1;
        bus.OUT2ADDRESS = r2;
        @(posedge CLK);
        #1;
        if (we) begin
            mem[wa]      = din;
            wr_model[wa] = 1'b1;
        end
        exp1 = mem[r1];
        exp2 = mem[r2];
        check_all(tag);
    endtask

    // Reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic pulse_reset(input string tag);
        #2;
        RESET = 1'b1;
        #1;
        model_clear();
        check_all(tag);
        @(negedge CLK);
        RESET = 1'b0;
        bus.WRITE = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] alu(input int sel, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (sel)
            1:       return DW'(a + b);
            2:       return a & b;
            3:       return a | b;
            default: return b;
        endcase
    endfunction

    initial begin
        logic [DW-1:0] res;
        RESET           = 1'b1;
        bus.WRITE       = 1'b0;
        bus.IN          = '0;
        bus.INADDRESS   = '0;
        bus.OUT1ADDRESS = '0;
        bus.OUT2ADDRESS = '0;
        model_clear();
        @(posedge CLK);
        #1;
        check_all("por");
        @(negedge CLK);
        RESET = 1'b0;

        // Test 1: reset after nonzero data, then every address reads 0.
        cycle("t1_w", 1'b1, 3'd6, 8'hA5, 3'd6, 3'd0);
        cycle("t1_w2", 1'b1, 3'd0, 8'h3C, 3'd6, 3'd0);
        pulse_reset("t1_rst");
        for (int a = 0; a < int'(NR); a++) cycle("t1_rd", 1'b0, 3'd0, 8'hEE, AW'(a), AW'(NR - 1 - a));

        // Test 2: basic write then read.
        cycle("t2_w1", 1'b1, 3'd1, 8'd5, 3'd0, 3'd0);
        cycle("t2_w2", 1'b1, 3'd2, 8'd7, 3'd0, 3'd0);
        cycle("t2_rd", 1'b0, 3'd0, 8'd0, 3'd1, 3'd2);
        check("t2_out1_const", bus.OUT1, 8'd5);
        check("t2_out2_const", bus.OUT2, 8'd7);
        check("t2_written_const", bus.WRITTEN, 8'h06);

        // Test 3: bypass on both ports.
        cycle("t3_byp", 1'b1, 3'd3, 8'd12, 3'd3, 3'd3);
        check("t3_out1_const", bus.OUT1, 8'd12);
        check("t3_out2_const", bus.OUT2, 8'd12);

        // Test 4: write disabled.
        cycle("t4_nowr", 1'b0, 3'd1, 8'hFF, 3'd1, 3'd1);
        check("t4_r1_const", bus.OUT1, 8'd5);
        check("t4_written_const", bus.WRITTEN, 8'h0E);

        // Test 5: reset dominates writes across two edges.
        #2;
        RESET           = 1'b1;
        bus.WRITE       = 1'b1;
        bus.INADDRESS   = 3'd4;
        bus.IN          = 8'd10;
        bus.OUT1ADDRESS = 3'd4;
        bus.OUT2ADDRESS = 3'd4;
        model_clear();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_all("t5_held");
        RESET     = 1'b0;
        bus.WRITE = 1'b0;
        cycle("t5_rd", 1'b0, 3'd4, 8'd10, 3'd4, 3'd4);
        check("t5_r4_const", bus.OUT1, 8'd0);
        check("t5_w4", {7'd0, bus.WRITTEN[4]}, 8'd0);

        // Test 6: ALU write-back loop for add, AND, OR.
        for (int s = 1; s <= 3; s++) begin
            logic [DW-1:0] a, b, want;
            a    = (s == 1) ? 8'd5 : 8'd10;
            b    = (s == 1) ? 8'd7 : 8'd12;
            want = (s == 1) ? 8'd12 : (s == 2) ? 8'd8 : 8'd14;
            cycle("t6_w1", 1'b1, 3'd1, a, 3'd0, 3'd0);
            cycle("t6_w2", 1'b1, 3'd2, b, 3'd0, 3'd0);
            cycle("t6_rd", 1'b0, 3'd0, 8'd0, 3'd1, 3'd2);
            res = alu(s, mem[1], mem[2]);
            cycle("t6_wb", 1'b1, 3'd3, res, 3'd3, 3'd0);
            check("t6_bypass", bus.OUT1, want);
            cycle("t6_rd3", 1'b0, 3'd0, 8'd0, 3'd3, 3'd3);
            check("t6_stored", bus.OUT1, want);
        end

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) pulse_reset("rnd_rst");
            cycle("rnd", 1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)),
                  DW'($urandom), AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file.md
# reg_file

Eight-entry, 8-bit register file that sits directly upstream and downstream of the ALU in the simple processor datapath. Two read ports drive the ALU operand inputs (`OUT1` to operand 1, `OUT2` to operand 2). The ALU result returns on `IN` and is written back through a single write port. Read outputs are registered with a one-cycle latency, and a same-cycle write to a register being read is forwarded to the output (write-through bypass).

## Interface
- `DATA_WIDTH`, default 8: width of each register and of the data ports.
- `ADDR_WIDTH`, default 3: address width. Depth is 2^ADDR_WIDTH, which is 8 entries.
- `CLK` input, 1 bit: single clock. All state updates occur on the rising edge.
- `RESET` input, 1 bit: asynchronous, active-high reset.
- `IN` input, DATA_WIDTH: write data (the ALU result).
- `INADDRESS` input, ADDR_WIDTH: write address.
- `WRITE` input, 1 bit: write enable, sampled on the rising edge of `CLK`.
- `OUT1ADDRESS` input, ADDR_WIDTH: read address for port 1.
- `OUT2ADDRESS` input, ADDR_WIDTH: read address for port 2.
- `OUT1` output, DATA_WIDTH: registered read data, port 1 (ALU operand 1).
- `OUT2` output, DATA_WIDTH: registered read data, port 2 (ALU operand 2).
- `WRITTEN` output, 2^ADDR_WIDTH bits: bit *i* is set once register *i* has been written since the last reset.

## Operation
- **Storage:** 2^ADDR_WIDTH registers of DATA_WIDTH bits each. All registers are general-purpose; none is hardwired to zero.
- **Write:** on rising `CLK` with `WRITE`=1 and `RESET`=0:
  - register[`INADDRESS`] takes `IN`;
  - `WRITTEN[INADDRESS]` is set to 1.
- **No write:** with `WRITE`=0, the register contents and `WRITTEN` are unchanged.
- **Read, every rising edge with `RESET`=0:**
  - `OUT1` takes `IN` if `WRITE`=1 and `INADDRESS`=`OUT1ADDRESS`; otherwise it takes register[`OUT1ADDRESS`] (the pre-edge value).
  - `OUT2` is updated by the same rule, using `OUT2ADDRESS`.
- **Both ports, same address:** legal. Both outputs carry identical data, including when the value is bypassed.
- **Read-only use:** the outputs refresh every cycle from the registers; no enable is required to read.
- **Reset (`RESET`=1, asynchronous):** takes effect immediately, without waiting for `CLK`.
  - All registers go to 0.
  - `OUT1` and `OUT2` go to 0.
  - `WRITTEN` goes to all zeros.
- **Writes during reset:** a write presented while `RESET`=1 is discarded. It does not take effect after `RESET` falls.
- **Reset mid-operation:** a write in progress on the edge where `RESET` rises is lost; reset dominates.
- **Width rules:** no arithmetic is performed and no truncation occurs. Addresses are always in range because depth = 2^ADDR_WIDTH.
- **Unknown inputs:** an X on `INADDRESS` while `WRITE`=1 is illegal stimulus. The bench must not drive it, and the design makes no guarantee.

## Timing
- **Read latency:** 1 cycle. An address presented before edge *n* appears on `OUT1`/`OUT2` after edge *n*.
- **Write latency:** the value is stored at edge *n*.
  - A read of the same address in the same cycle returns the new value after edge *n*, through the bypass.
  - A read of that address in a later cycle returns it from storage.
- **Write-back loop:** with `OUT1`/`OUT2` feeding the ALU combinationally and the ALU result feeding `IN`, one instruction completes per cycle: read at edge *n*, ALU settles, write at edge *n+1*.
- **Reset release:** the first write is accepted on the first rising edge after `RESET` falls, provided setup time is met.
- **Output timing:** `OUT1`, `OUT2` and `WRITTEN` change only on a rising `CLK` edge or on assertion of `RESET`. There are no combinational paths from inputs to outputs.

## Test plan
1. **Reset:** assert `RESET` mid-cycle after registers hold nonzero data.
   - Expect `OUT1`=`OUT2`=0 and `WRITTEN`=8'h00 immediately, before the next edge.
   - After release, reading every address returns 0.
2. **Basic write and read:**
   - Stimulus: write 5 to r1 at edge 1 and 7 to r2 at edge 2; at edge 3 set `OUT1ADDRESS`=1 and `OUT2ADDRESS`=2.
   - Expect, after edge 3: `OUT1`=5, `OUT2`=7, `WRITTEN`=8'h06.
3. **Bypass:**
   - Stimulus: `WRITE`=1, `INADDRESS`=3, `IN`=12, with `OUT1ADDRESS`=`OUT2ADDRESS`=3 in the same cycle.
   - Expect `OUT1`=`OUT2`=12 after that edge, not the old r3 value.
4. **Write disabled:**
   - Stimulus: `WRITE`=0 with `IN`=8'hFF and `INADDRESS`=1.
   - Expect r1 to stay 5 and `WRITTEN` to be unchanged.
5. **Reset dominance:** hold `RESET`=1 while presenting `WRITE`=1, `INADDRESS`=4, `IN`=10 across two edges; then release.
   - Expect a read of r4 to return 0 and `WRITTEN[4]`=0.
6. **ALU loop:**
   - Stimulus: r1=5, r2=7; ALU select=1 (add); read r1/r2 and write the result to r3; next cycle read r3.
   - Expect `OUT1`=12.
   - Repeat with select=2 (AND) on 10 and 12: expect 8. Repeat with select=3 (OR): expect 14.
